// File: rtl/my_pkg.sv
// rtl/my_pkg.sv - shared types and constants for the CPU memories
package my_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int LANES = DATA_WIDTH / 8;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;
  localparam int DEFAULT_DEPTH_LOG2 = 6;

  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_BAD = 2'b11} access_size_t;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} ram_state_t;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef word_t ram_default_t [2**DEFAULT_DEPTH_LOG2];

endpackage

// File: rtl/ram_lane_ext.sv
// rtl/ram_lane_ext.sv - byte-lane selection, store merge and load extension
module ram_lane_ext
  import my_pkg::*;
(
  input  access_size_t          size,
  input  logic                  uns,
  input  logic [1:0]            lane,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [LANES-1:0]      be,
  output logic [DATA_WIDTH-1:0] merged,
  output logic [DATA_WIDTH-1:0] load,
  output logic                  misalign
);

  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] rep;

  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    be       = '0;
    rep      = wdata;
    load     = '0;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        be   = 4'b0001 << lane;
        rep  = {4{wdata[7:0]}};
        load = uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        rep      = {2{wdata[15:0]}};
        load     = uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        misalign = lane[0];
      end
      SZ_WORD: begin
        be       = 4'b1111;
        load     = word;
        misalign = (lane != 2'b00);
      end
      default: be = '0;
    endcase
  end

  // Replicated store data lands on every lane; be picks which lanes take it.
  always_comb begin
    merged = word;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) merged[8*i +: 8] = rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_ram.sv
// rtl/data_ram.sv - data-segment RAM with req/ack handshake and sized access
module data_ram
  import my_pkg::*;
#(
  parameter int          DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter logic [31:0] BASE_ADDR  = DATA_BASE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack,
  output logic                  err,
  output logic                  busy
);

  ram_state_t            state;
  logic                  a_we;
  access_size_t          a_size;
  logic                  a_uns;
  logic [31:0]           a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;

  word_t                 mem [2**DEPTH_LOG2];

  logic [31:0]           off;
  logic                  out_of_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic [LANES-1:0]      be;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] load;
  logic                  misalign;
  logic                  bad;

  assign busy = (state == ACCESS);

  // The low-side compare catches the wrap of the unsigned subtraction.
  assign off          = a_addr - BASE_ADDR;
  assign out_of_range = (a_addr < BASE_ADDR) || (off[31:DEPTH_LOG2+2] != '0);
  assign idx          = off[DEPTH_LOG2+1:2];
  assign bad          = out_of_range || (a_size == SZ_BAD) || misalign;

  ram_lane_ext u_lane (
    .size    (a_size),
    .uns     (a_uns),
    .lane    (off[1:0]),
    .wdata   (a_wdata),
    .word    (mem[idx]),
    .be      (be),
    .merged  (merged),
    .load    (load),
    .misalign(misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rdata   <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      a_we    <= 1'b0;
      a_size  <= SZ_BYTE;
      a_uns   <= 1'b0;
      a_addr  <= '0;
      a_wdata <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            a_we    <= we;
            a_size  <= access_size_t'(size);
            a_uns   <= uns;
            a_addr  <= addr;
            a_wdata <= wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          ack   <= 1'b1;
          err   <= bad;
          rdata <= (bad || a_we) ? '0 : load;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset forces state to IDLE asynchronously, so a dropped access never writes.
  always_ff @(posedge clk) begin
    if (state == ACCESS && a_we && !bad && (|be)) mem[idx] <= merged;
  end

endmodule

// File: tb/tb_data_ram.sv
// tb/tb_data_ram.sv - directed self-checking bench for data_ram
module tb_data_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  data_ram dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .we   (we),
    .size (size),
    .uns  (uns),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .ack  (ack),
    .err  (err),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Issues one request from a negedge and waits (bounded) for ack; lat=-1 if none.
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    lat = -1; rd = 'x; e = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) req = 1'b0;
      if (ack) begin
        lat = i; rd = rdata; e = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rdata, ack, err, busy} !== 35'd0) begin
      errors++;
      $display("FAIL reset_state: rdata=%h ack=%b err=%b busy=%b, required all zero", rdata, ack, err, busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    logic [31:0] rd; logic e; int lat;
    access(1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'hDEAD_BEEF, rd, e, lat);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sw_word: lat=%0d err=%b rdata=%h, required lat=2 err=0 rdata=0", lat, e, rd);
    end
    access(1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0, rd, e, lat);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL lw_word: lat=%0d err=%b rdata=%h, required lat=2 err=0 rdata=deadbeef", lat, e, rd);
    end
    access(1'b1, 2'b10, 1'b0, 32'h1001_00FC, 32'hCAFE_F00D, rd, e, lat);
    access(1'b0, 2'b10, 1'b0, 32'h1001_00FC, 32'h0, rd, e, lat);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL lw_last_word: lat=%0d err=%b rdata=%h, required lat=2 err=0 rdata=cafef00d", lat, e, rd);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic e; int lat;
    access(1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'h1122_3344, rd, e, lat);
    access(1'b1, 2'b00, 1'b0, 32'h1001_0005, 32'h0000_0080, rd, e, lat);
    access(1'b0, 2'b00, 1'b0, 32'h1001_0005, 32'h0, rd, e, lat);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rd !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb: lat=%0d err=%b rdata=%h, required ffffff80", lat, e, rd);
    end
    access(1'b0, 2'b00, 1'b1, 32'h1001_0005, 32'h0, rd, e, lat);
    checks++;
    if (e !== 1'b0 || rd !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu: err=%b rdata=%h, required 00000080", e, rd);
    end
    access(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, rd, e, lat);
    checks++;
    if (e !== 1'b0 || rd !== 32'h1122_8044) begin
      errors++;
      $display("FAIL lw_after_sb: err=%b rdata=%h, required 11228044", e, rd);
    end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic e; int lat;
    access(1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'hAAAA_AAAA, rd, e, lat);
    access(1'b1, 2'b01, 1'b0, 32'h1001_0002, 32'h0000_1234, rd, e, lat);
    access(1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0, rd, e, lat);
    checks++;
    if (e !== 1'b0 || rd !== 32'h1234_AAAA) begin
      errors++;
      $display("FAIL lw_after_sh: err=%b rdata=%h, required 1234aaaa", e, rd);
    end
    access(1'b0, 2'b01, 1'b0, 32'h1001_0002, 32'h0, rd, e, lat);
    checks++;
    if (e !== 1'b0 || rd !== 32'h0000_1234) begin
      errors++;
      $display("FAIL lh_hi: err=%b rdata=%h, required 00001234", e, rd);
    end
    access(1'b0, 2'b01, 1'b0, 32'h1001_0000, 32'h0, rd, e, lat);
    checks++;
    if (e !== 1'b0 || rd !== 32'hFFFF_AAAA) begin
      errors++;
      $display("FAIL lh_lo_sext: err=%b rdata=%h, required ffffaaaa", e, rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    logic        v_we   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]  v_size [7] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10};
    logic [31:0] v_addr [7] = '{32'h1001_0002, 32'h1001_0001, 32'h1001_0100,
                                32'h0FFF_FFFC, 32'h1001_0000, 32'h1001_0000, 32'hFFFF_FFFC};
    for (int i = 0; i < 7; i++) begin
      access(v_we[i], v_size[i], 1'b0, v_addr[i], 32'hFFFF_FFFF, rd, e, lat);
      checks++;
      if (lat !== 2 || e !== 1'b1 || rd !== 32'h0) begin
        errors++;
        $display("FAIL err_case_%0d: lat=%0d err=%b rdata=%h, required lat=2 err=1 rdata=0", i, lat, e, rd);
      end
    end
    access(1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0, rd, e, lat);
    checks++;
    if (e !== 1'b0 || rd !== 32'h1234_AAAA) begin
      errors++;
      $display("FAIL err_no_write: err=%b rdata=%h, required 1234aaaa", e, rd);
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int bad_busy = 0;
    int bad_data = 0;
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h1001_0000; wdata = '0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 6) req = 1'b0;
      if (k <= 6 && busy !== ((k % 2) == 1)) bad_busy++;
      if (ack) begin
        acks++;
        if (rdata !== 32'h1234_AAAA || err !== 1'b0) bad_data++;
      end
    end
    checks++;
    if (acks !== 3) begin
      errors++;
      $display("FAIL b2b_ack_count: got %0d acks, required 3", acks);
    end
    checks++;
    if (bad_busy !== 0) begin
      errors++;
      $display("FAIL b2b_busy_alternate: %0d wrong busy samples, required 0", bad_busy);
    end
    checks++;
    if (bad_data !== 0) begin
      errors++;
      $display("FAIL b2b_rdata: %0d wrong responses, required 0", bad_data);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd; logic e; int lat;
    int acks = 0;
    access(1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'h0102_0304, rd, e, lat);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h1001_0008; wdata = 32'h5555_5555;
    @(posedge clk);
    #2;
    req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_busy: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_drop: busy=%b ack=%b, required 0 0", busy, ack);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL rst_no_ack: got %0d acks, required 0", acks);
    end
    access(1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0, rd, e, lat);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rd !== 32'h0102_0304) begin
      errors++;
      $display("FAIL rst_no_write: lat=%0d err=%b rdata=%h, required 01020304", lat, e, rd);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram.md
Name: data_ram

Overview:
- Read/write data memory that pairs with the read-only instruction memory.
- Serves CPU loads and stores to the data segment, which starts at 0x1001_0000.
- Uses a req/ack handshake with a registered response.
- Supports byte, half-word and word access with little-endian byte lanes and sign/zero extension on loads.
- Flags out-of-range and misaligned accesses instead of touching memory.

Parameters:
- DATA_WIDTH, 32, word width (taken from my_pkg).
- DEPTH_LOG2, 6, log2 of the number of words (64 words).
- BASE_ADDR, 32'h1001_0000, byte address of word 0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only when busy=0.
- we  in  1  1=store, 0=load.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- uns  in  1  loads only: 1=zero-extend, 0=sign-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  out  32  load result, extended to 32 bits.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; access rejected.
- busy  out  1  request in flight.

Behaviour:
- Reset (async, any time): state=IDLE; rdata=0, ack=0, err=0, busy=0. Memory contents are not cleared.
- Reset mid-operation: an in-flight access is dropped, no write occurs, and no ack is issued.
- FSM has two states, IDLE and ACCESS.
  - IDLE: busy=0. When req=1 at edge E0, latch we, size, uns, addr, wdata; go to ACCESS.
  - ACCESS: busy=1 (combinational from state). At edge E1, perform the access, register the response and return to IDLE.
  - ack=1 and err are valid for exactly the cycle after E1.
- Latency: 2 edges from req to the ack pulse.
- Back-to-back: req may be held high. It is re-sampled in the IDLE cycle in which ack is high, so throughput is one access per 2 cycles.
- req while busy=1 is ignored; it is not queued.
- Offset: off = addr - BASE_ADDR, computed as a 32-bit unsigned subtraction.
  - Out of range when addr < BASE_ADDR or off >= 4*2^DEPTH_LOG2 (wrap of the subtraction is caught by the first test).
  - Word index = off[DEPTH_LOG2+1:2].
- Error cases (evaluated in ACCESS, all produce ack=1, err=1, rdata=0, no memory write):
  - out of range;
  - size=11;
  - half-word access with addr[0]=1;
  - word access with addr[1:0]!=0.
- Store (we=1, legal):
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - word: all four lanes.
  - Untouched lanes keep their value. ack=1, err=0, rdata=0.
- Load (we=0, legal):
  - Select the lane(s) using the same rules as stores.
  - Extend to 32 bits: sign-extend when uns=0, zero-extend when uns=1 (ignored for words).
  - rdata holds its value until the next ack.
- Lane 0 is bits [7:0] (little-endian).
- Read-after-write to the same address on the next request returns the new data.

Decomposition:
- my_pkg gains:
  - DATA_BASE constant (32'h1001_0000);
  - enum access_size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD};
  - typedef for the RAM array, parameterised by depth;
  - enum ram_state_t {IDLE, ACCESS}.
- Sub-module ram_lane_ext (combinational):
  - given size, uns, addr[1:0], wdata and the stored word, produces byte-enable[3:0], the merged write word, the extended load data and a misalign flag.
- data_ram keeps the FSM, request latches, range check and storage.

Test Plan:
- Reset then word store: sw addr=0x1001_0000 wdata=0xDEAD_BEEF; then lw same address -> each ack 2 cycles after req, err=0, rdata=0xDEAD_BEEF.
- Byte lanes: sb 0x1001_0005 wdata=0x80; then lb -> rdata=0xFFFF_FF80; then lbu -> rdata=0x0000_0080; then lw 0x1001_0004 -> only bits [15:8] changed.
- Half-word: sh 0x1001_0002 wdata=0x1234 after a word store of 0xAAAA_AAAA -> lw 0x1001_0000 gives 0x1234_AAAA; lh 0x1001_0002 gives 0x0000_1234.
- Errors, each giving ack=1, err=1, rdata=0 and memory unchanged on re-read:
  - lw 0x1001_0002 (misaligned);
  - sh 0x1001_0001 (misaligned);
  - lw 0x1001_0100 (off=256, out of range);
  - lw 0x0FFF_FFFC (below base);
  - size=11.
- Handshake: hold req high for 6 cycles -> exactly 3 acks, busy alternates 1/0, req during busy is not double-counted.
- Async reset in ACCESS of sw 0x1001_0008 wdata=0x5555_5555 -> no ack, busy=0 immediately, a later lw returns the prior contents.
